instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter WordSize, default 32: PC and address width.
REQ-002 Parameter ResetVector, default 32'h0000_0000: first fetch address.
REQ-003 Ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Ports: rstn  in  1  reset, asynchronous, active-low.
REQ-005 Ports: redirect_valid  in  1  branch taken (from branch address calculator).
REQ-006 Ports: redirect_addr  in  WordSize  branch target.
REQ-007 Ports: imem_req  out  1  fetch request to instruction memory.
REQ-008 Ports: imem_addr  out  WordSize  fetch address.
REQ-009 Ports: imem_gnt  in  1  memory accepts request this cycle.
REQ-010 Ports: imem_rvalid  in  1  read data valid.
REQ-011 Ports: imem_rdata  in  32  instruction word.
REQ-012 Ports: if_valid  out  1  instruction available downstream.
REQ-013 Ports: if_ready  in  1  downstream accepts.
REQ-014 Ports: if_pc  out  WordSize  PC of held instruction.
REQ-015 Ports: if_pc_plus4  out  WordSize  sequential successor PC.
REQ-016 Ports: if_instr  out  32  held instruction.
REQ-017 Ports: fetch_misalign  out  1  redirect target not word-aligned.

Function
REQ-018 FSM states: IDLE, REQ, WAIT, HOLD, FAULT; one fetch outstanding maximum.
REQ-019 IDLE -> REQ unconditionally next cycle; imem_req=0 in IDLE.
REQ-020 REQ: imem_req=1, imem_addr=pc_q; on imem_gnt -> WAIT.
REQ-021 WAIT: imem_req=0; on imem_rvalid capture imem_rdata and pc_q into holding buffer -> HOLD; if_valid rises the following cycle (registered, 1-cycle latency from rvalid).
REQ-022 HOLD: if_valid=1; on if_valid&&if_ready, pc_q <= pc_q+4 (mod 2^WordSize, wraps silently) -> REQ.
REQ-023 if_pc_plus4 = if_pc + 4, WordSize-bit truncating add.
REQ-024 Redirect in REQ without gnt: pc_q <= redirect_addr, remain REQ; imem_addr changes next cycle.
REQ-025 Redirect in REQ coincident with gnt: squash flag set, pc_q <= redirect_addr -> WAIT.
REQ-026 Redirect in WAIT: set squash flag, pc_q <= redirect_addr; returning data discarded, then -> REQ.
REQ-027 Squashed response arriving in same cycle as a second redirect: data discarded, latest redirect_addr wins.
REQ-028 Redirect in HOLD: buffer dropped, pc_q <= redirect_addr -> REQ; if_valid is gated low in that cycle so no handshake occurs even if if_ready=1.
REQ-029 redirect_addr[1:0]!=0: -> FAULT, fetch_misalign=1, imem_req=0, if_valid=0; only an aligned redirect exits FAULT (-> REQ). If a fetch is outstanding, its response is absorbed before imem_req re-asserts.
REQ-030 imem_rvalid outside WAIT (non-squash) is ignored.

Reset
REQ-031 rstn low asynchronously forces: state=IDLE, pc_q=ResetVector, squash=0, imem_req=0, imem_addr=ResetVector, if_valid=0, if_pc=0, if_pc_plus4=4, if_instr=0, fetch_misalign=0.
REQ-032 Reset mid-transaction abandons any outstanding fetch; a stale imem_rvalid after reset release is ignored (state IDLE/REQ).

Structure
REQ-033 Shared package fetch_pkg holds the FSM state enum, INSTR_BYTES=4, and the alignment mask constant.
REQ-034 One sub-module, fetch_buffer: single-entry holding register (pc, instr, valid) with load, drop and pop controls.

Verification
REQ-035 Reset release, gnt immediate, rvalid 1 cycle later with rdata=32'h00000013, if_ready=1 -> imem_addr=0, then if_pc=0, if_instr=32'h13, next imem_addr=4.
REQ-036 if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc, if_instr stable, imem_req=0 throughout.
REQ-037 Redirect to 32'h100 while in WAIT, old rdata=32'hDEADBEEF -> data never presented; next imem_addr=32'h100.
REQ-038 Redirect to 32'h200 in HOLD with if_ready=1 same cycle -> no handshake, next imem_addr=32'h200.
REQ-039 Redirect to 32'h102 -> fetch_misalign=1, imem_req=0 until redirect to 32'h104, then imem_addr=32'h104.
REQ-040 pc_q=32'hFFFFFFFC accepted -> next imem_addr=0, if_pc_plus4 was 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   fetch_state_e : fetch controller FSM state encoding
//   INSTR_BYTES   : size of one instruction in bytes (sequential PC step)
//   ALIGN_MASK    : low address bits that must be zero for a legal fetch target
//   addr_aligned  : helper that tests the low address bits against ALIGN_MASK
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 32'd4;
    localparam logic [1:0]  ALIGN_MASK  = 2'b11;

    function automatic logic addr_aligned(input logic [1:0] low_bits);
        return (low_bits & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: single-entry holding register for a fetched instruction.
// Ports:
//   clk, rstn    : clock, asynchronous active-low reset
//   i_load       : capture i_pc / i_instr and mark the entry valid
//   i_drop       : discard the entry (redirect)
//   i_pop        : entry consumed downstream
//   i_pc         : PC of the instruction being captured
//   i_instr      : instruction word being captured
//   o_valid      : entry holds an instruction
//   o_pc         : PC of the held instruction
//   o_pc_plus4   : sequential successor of o_pc
//   o_instr      : held instruction word
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned WordSize = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_load,
    input  logic                i_drop,
    input  logic                i_pop,
    input  logic [WordSize-1:0] i_pc,
    input  logic [31:0]         i_instr,
    output logic                o_valid,
    output logic [WordSize-1:0] o_pc,
    output logic [WordSize-1:0] o_pc_plus4,
    output logic [31:0]         o_instr
);

    logic                r_valid;
    logic [WordSize-1:0] r_pc;
    logic [WordSize-1:0] r_pc_plus4;
    logic [31:0]         r_instr;

    // Holding register: load wins; drop/pop only clear the valid flag so the
    // last PC/instruction stay visible on the outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_pc_plus4 <= WordSize'(INSTR_BYTES);
            r_instr    <= 32'h0000_0000;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc + WordSize'(INSTR_BYTES);
            r_instr    <= i_instr;
        end else if (i_drop || i_pop) begin
            r_valid    <= 1'b0;
        end else begin
            r_valid    <= r_valid;
        end
    end

    assign o_valid    = r_valid;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_instr    = r_instr;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetch controller.
// Ports:
//   clk, rstn                    : clock, asynchronous active-low reset
//   redirect_valid/redirect_addr : taken branch and its target
//   imem_req/imem_addr           : fetch request and address to instruction memory
//   imem_gnt                     : memory accepted the request
//   imem_rvalid/imem_rdata       : read response
//   if_valid/if_ready            : downstream handshake
//   if_pc/if_pc_plus4/if_instr   : held instruction, its PC and successor PC
//   fetch_misalign               : last redirect target was not word-aligned
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned         WordSize    = 32,
    parameter logic [WordSize-1:0] ResetVector = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                redirect_valid,
    input  logic [WordSize-1:0] redirect_addr,
    output logic                imem_req,
    output logic [WordSize-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [WordSize-1:0] if_pc,
    output logic [WordSize-1:0] if_pc_plus4,
    output logic [31:0]         if_instr,
    output logic                fetch_misalign
);

    fetch_state_e        r_state;
    fetch_state_e        w_state_nxt;
    logic [WordSize-1:0] r_pc;
    logic [WordSize-1:0] w_pc_nxt;
    // r_squash marks a granted fetch whose response must be thrown away;
    // it doubles as the "response still outstanding" flag while in FAULT.
    logic                r_squash;
    logic                w_squash_nxt;
    logic                r_imem_req;
    logic [WordSize-1:0] r_imem_addr;
    logic                r_misalign;
    logic                w_load;
    logic                w_drop;
    logic                w_pop;
    logic                w_redir_ok;
    logic                w_redir_bad;
    logic                w_buf_valid;

    assign w_redir_ok  = redirect_valid &&  addr_aligned(redirect_addr[1:0]);
    assign w_redir_bad = redirect_valid && !addr_aligned(redirect_addr[1:0]);

    // Next-state, next-PC and buffer control decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_squash_nxt = r_squash;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_redir_bad) begin
                    w_state_nxt = ST_FAULT;
                end else if (w_redir_ok) begin
                    w_pc_nxt    = redirect_addr;
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    // A redirect alongside the grant leaves a response in flight.
                    w_squash_nxt = redirect_valid;
                    if (w_redir_bad) begin
                        w_state_nxt = ST_FAULT;
                    end else if (w_redir_ok) begin
                        w_pc_nxt    = redirect_addr;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end else if (w_redir_bad) begin
                    w_state_nxt = ST_FAULT;
                end else if (w_redir_ok) begin
                    w_pc_nxt = redirect_addr;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    w_squash_nxt = 1'b0;
                    if (w_redir_bad) begin
                        w_state_nxt = ST_FAULT;
                    end else if (w_redir_ok) begin
                        w_pc_nxt    = redirect_addr;
                        w_state_nxt = ST_REQ;
                    end else if (r_squash) begin
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end else if (w_redir_bad) begin
                    w_squash_nxt = 1'b1;
                    w_state_nxt  = ST_FAULT;
                end else if (w_redir_ok) begin
                    w_squash_nxt = 1'b1;
                    w_pc_nxt     = redirect_addr;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (w_redir_bad) begin
                    w_drop      = 1'b1;
                    w_state_nxt = ST_FAULT;
                end else if (w_redir_ok) begin
                    w_drop      = 1'b1;
                    w_pc_nxt    = redirect_addr;
                    w_state_nxt = ST_REQ;
                end else if (if_ready) begin
                    w_pop       = 1'b1;
                    w_pc_nxt    = r_pc + WordSize'(INSTR_BYTES);
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_FAULT: begin
                if (imem_rvalid) begin
                    w_squash_nxt = 1'b0;
                end else begin
                    w_squash_nxt = r_squash;
                end
                if (w_redir_ok) begin
                    w_pc_nxt = redirect_addr;
                    // Still waiting on a response: absorb it in WAIT first.
                    if (r_squash && !imem_rvalid) begin
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end else begin
                    w_state_nxt = ST_FAULT;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_squash_nxt = 1'b0;
            end
        endcase
    end

    // Controller state, fetch PC and squash flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_pc     <= ResetVector;
            r_squash <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_squash <= w_squash_nxt;
        end
    end

    // Memory-side and fault outputs, registered from the next-state decode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_imem_req  <= 1'b0;
            r_imem_addr <= ResetVector;
            r_misalign  <= 1'b0;
        end else begin
            r_imem_req  <= (w_state_nxt == ST_REQ);
            r_imem_addr <= w_pc_nxt;
            r_misalign  <= (w_state_nxt == ST_FAULT);
        end
    end

    fetch_buffer #(
        .WordSize   (WordSize)
    ) u_fetch_buffer (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (w_load),
        .i_drop     (w_drop),
        .i_pop      (w_pop),
        .i_pc       (r_pc),
        .i_instr    (imem_rdata),
        .o_valid    (w_buf_valid),
        .o_pc       (if_pc),
        .o_pc_plus4 (if_pc_plus4),
        .o_instr    (if_instr)
    );

    assign imem_req       = r_imem_req;
    assign imem_addr      = r_imem_addr;
    assign fetch_misalign = r_misalign;
    // A redirect in HOLD kills the held instruction in the same cycle.
    assign if_valid       = w_buf_valid && !redirect_valid;

endmodule
